// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
// Shared definitions for the SPI register-write initiator: frame layout,
// field widths, peripheral register map and the controller state encoding.
// No ports.
package spi_ctrl_pkg;

  localparam int FRAME_W   = 16;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int WRITE_BIT = 15;

  // Register map of the SPI peripheral on the far end of the link.
  localparam logic [ADDR_W-1:0] REG_ADDR_0 = 7'h00;
  localparam logic [ADDR_W-1:0] REG_ADDR_1 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_ADDR_2 = 7'h02;
  localparam logic [ADDR_W-1:0] REG_ADDR_3 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_ADDR_4 = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              write,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {write, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if
// Command-side bundle of the SPI initiator.
//   master : command source (drives cmd_valid/cmd_write/cmd_addr/cmd_data)
//   slave  : spi_controller (drives cmd_ready/busy/done/rx_data/rx_valid)
interface spi_controller_if;
  import spi_ctrl_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;
  logic                busy;
  logic                done;
  logic [FRAME_W-1:0]  rx_data;
  logic                rx_valid;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, rx_data, rx_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    output cmd_ready, busy, done, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
// Phase timer for the SPI initiator. Down-counter reloaded with CLK_DIV-1
// whenever the controller changes state; o_phase_end is high on the last
// clk cycle of the current phase.
//   clk, rst_n   : system clock, async active-low reset
//   i_reload     : controller changes state at the next edge
//   o_phase_end  : current phase ends at the next edge
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_reload,
  output logic o_phase_end
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_reload) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_phase_end = (r_cnt == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// spi_controller
// SPI mode-0 initiator that serialises 16-bit register-write frames
// {write, addr[6:0], data[7:0]} MSB first. All SPI timing derives from clk.
//   clk, rst_n : system clock, async active-low reset
//   cmd        : spi_controller_if.slave (valid/ready command, busy, done, rx)
//   sclk, ncs  : SPI clock (idle low) and chip select (active low)
//   copi, cipo : serial data out / in
// Build option: define SPI_CTRL_CIPO_EN to capture cipo into rx_data;
// otherwise cipo is ignored and rx_data/rx_valid are tied to zero.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a handshake
// SETUP | ncs low, copi = bit 15, sclk low for one phase
// HIGH  | sclk high for one phase (receiver samples here)
// LOW   | sclk low for one phase, copi advanced on entry
// HOLD  | sclk low, copi holds bit 0 for one phase before ncs rises
// GAP   | ncs high for CS_GAP cycles, done pulsed on entry
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  cmd,
  output logic             sclk,
  output logic             ncs,
  output logic             copi,
  input  logic             cipo
);

  localparam logic [15:0] GAP_LOAD = 16'(CS_GAP - 1);

  state_t              r_state;
  logic [FRAME_W-1:0]  r_shift;
  logic [3:0]          r_bits;
  logic [15:0]         r_gap_cnt;
  logic                r_sclk;
  logic                r_ncs;
  logic                r_copi;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  logic w_phase_end;
  logic w_accept;
  logic w_reload;

  assign w_accept = cmd.cmd_valid & r_ready;
  // Every timed phase restarts the divider; GAP has its own counter.
  assign w_reload = w_accept |
                    (w_phase_end & ((r_state == ST_SETUP) | (r_state == ST_HIGH) |
                                    (r_state == ST_LOW)   | (r_state == ST_HOLD)));

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_reload    (w_reload),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bits    <= 4'd0;
      r_gap_cnt <= 16'd0;
      r_sclk    <= 1'b0;
      r_ncs     <= 1'b1;
      r_copi    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_shift <= build_frame(cmd.cmd_write, cmd.cmd_addr, cmd.cmd_data);
            r_bits  <= 4'd15;
            r_ncs   <= 1'b0;
            r_sclk  <= 1'b0;
            r_copi  <= cmd.cmd_write;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_phase_end) begin
            r_state <= ST_HIGH;
            r_sclk  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_phase_end) begin
            r_sclk <= 1'b0;
            // r_bits counts rises still to come after this one
            if (r_bits != 4'd0) begin
              r_state <= ST_LOW;
              r_bits  <= r_bits - 4'd1;
              r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
              r_copi  <= r_shift[FRAME_W-2];
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_LOW: begin
          if (w_phase_end) begin
            r_state <= ST_HIGH;
            r_sclk  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_phase_end) begin
            r_ncs  <= 1'b1;
            r_copi <= 1'b0;
            r_done <= 1'b1;
            // Ready is raised one edge early so the next handshake lands
            // exactly CS_GAP cycles after ncs rises.
            if (CS_GAP == 1) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt - 16'd1;
          if (r_gap_cnt == 16'd1) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk          = r_sclk;
  assign ncs           = r_ncs;
  assign copi          = r_copi;
  assign cmd.cmd_ready = r_ready;
  assign cmd.busy      = r_busy;
  assign cmd.done      = r_done;

`ifdef SPI_CTRL_CIPO_EN
  logic               r_cipo_s1;
  logic               r_cipo_s2;
  logic [FRAME_W-1:0] r_rx_shift;
  logic [FRAME_W-1:0] r_rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cipo_s1 <= 1'b0;
      r_cipo_s2 <= 1'b0;
    end else begin
      r_cipo_s1 <= cipo;
      r_cipo_s2 <= r_cipo_s1;
    end
  end

  // Sample on the last cycle of HIGH: the peripheral changed cipo on the
  // preceding falling edge, long enough ago to have cleared the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= '0;
      r_rx_data  <= '0;
    end else begin
      if (w_accept) begin
        r_rx_shift <= '0;
      end else if ((r_state == ST_HIGH) && w_phase_end) begin
        r_rx_shift <= {r_rx_shift[FRAME_W-2:0], r_cipo_s2};
      end
      if ((r_state == ST_HOLD) && w_phase_end) begin
        r_rx_data <= r_rx_shift;
      end
    end
  end

  assign cmd.rx_data  = r_rx_data;
  assign cmd.rx_valid = r_done;
`else
  logic w_unused_cipo;
  assign w_unused_cipo = cipo;
  assign cmd.rx_data   = '0;
  assign cmd.rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
module tb_spi_controller;
  import spi_ctrl_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, ncs, copi;
  logic cipo  = 1'b0;

  spi_controller_if cmd_if ();

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd_if.slave),
    .sclk  (sclk),
    .ncs   (ncs),
    .copi  (copi),
    .cipo  (cipo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    int          nbits;
    int          fall_cyc;
    int          rise_cyc;
    int          first_rise;
    int          last_rise;
    logic        done_at_rise;
    logic [15:0] rx;
    logic        rxv;
  } frame_t;

  frame_t      frames[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_total = 0;
  int          flag_err = 0;
  int          rxv_err  = 0;
  int          cur_bits = 0;
  logic [15:0] cur_val;
  int          cur_fall, cur_first, cur_last;
  bit          in_frame = 0;
  logic [7:0]  regs     [5];
  logic [7:0]  exp_regs [5];
  logic [15:0] cipo_word = 16'h0000;

`ifdef SPI_CTRL_CIPO_EN
  localparam bit CIPO_EN = 1'b1;
`else
  localparam bit CIPO_EN = 1'b0;
`endif

  // Bus observer and behavioural peripheral: collects sclk-rise samples of
  // copi per ncs-low window and applies completed writes to a register array.
  initial begin
    logic p_ncs, p_sclk, exp_rxv;
    p_ncs = 1'b1; p_sclk = 1'b0;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_frame = 0; cur_bits = 0; p_ncs = 1'b1; p_sclk = 1'b0;
        for (int i = 0; i < 5; i++) regs[i] = 8'h00;
      end else begin
        if (p_ncs && !ncs) begin
          in_frame = 1; cur_val = 16'h0; cur_bits = 0; cur_fall = cyc;
        end
        if (!p_sclk && sclk && !ncs) begin
          cur_val = {cur_val[14:0], copi};
          if (cur_bits == 0) cur_first = cyc;
          cur_last = cyc;
          cur_bits++;
        end
        if (cmd_if.done) done_total++;
        if (cmd_if.busy === cmd_if.cmd_ready) flag_err++;
        if (!ncs && !cmd_if.busy) flag_err++;
        exp_rxv = CIPO_EN ? cmd_if.done : 1'b0;
        if (cmd_if.rx_valid !== exp_rxv) rxv_err++;
        if (!p_ncs && ncs && in_frame) begin
          frames.push_back('{cur_val, cur_bits, cur_fall, cyc, cur_first, cur_last,
                             cmd_if.done, cmd_if.rx_data, cmd_if.rx_valid});
          if (cur_bits == 16 && cur_val[15] && cur_val[14:8] < 7'd5)
            regs[int'(cur_val[14:8])] = cur_val[7:0];
          in_frame = 0;
        end
        p_ncs = ncs; p_sclk = sclk;
      end
    end
  end

  // Peripheral cipo driver: bit 15 on ncs fall, next bit after each sclk fall.
  initial begin
    logic q_ncs, q_sclk;
    int   idx;
    q_ncs = 1'b1; q_sclk = 1'b0; idx = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cipo = 1'b0; q_ncs = 1'b1; q_sclk = 1'b0; idx = -1;
      end else begin
        if (q_ncs && !ncs) begin
          cipo = cipo_word[15]; idx = 14;
        end else if (q_sclk && !sclk && !ncs && idx >= 0) begin
          cipo = cipo_word[idx]; idx--;
        end
        q_ncs = ncs; q_sclk = sclk;
      end
    end
  end

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
    bit ok;
    ok = 0;
    @(negedge clk);
    cmd_if.cmd_write = w; cmd_if.cmd_addr = a; cmd_if.cmd_data = d;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_if.cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL send_accept: cmd_ready never seen, required 1"); end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 2000 && frames.size() < n; i++) @(negedge clk);
    n_checks++;
    if (frames.size() < n) begin
      n_fail++;
      $display("FAIL wait_frame: got %0d frames, required %0d", frames.size(), n);
    end
  endtask

  task automatic model_write(input logic w, input logic [6:0] a, input logic [7:0] d);
    if (w && a < 7'd5) exp_regs[int'(a)] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (ncs !== 1'b1)   begin n_fail++; $display("FAIL rst_ncs: got %b required 1", ncs); end
    if (sclk !== 1'b0)  begin n_fail++; $display("FAIL rst_sclk: got %b required 0", sclk); end
    if (copi !== 1'b0)  begin n_fail++; $display("FAIL rst_copi: got %b required 0", copi); end
    if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", cmd_if.cmd_ready); end
    if (cmd_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", cmd_if.busy); end
    if (cmd_if.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", cmd_if.done); end
    if (cmd_if.rx_data !== 16'h0) begin n_fail++; $display("FAIL rst_rx_data: got %h required 0000", cmd_if.rx_data); end
    if (cmd_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b required 0", cmd_if.rx_valid); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int base, d0;
    frame_t f;
    base = frames.size(); d0 = done_total;
    cipo_word = 16'hBEEF;
    send(1'b1, REG_ADDR_4, 8'h80);
    model_write(1'b1, REG_ADDR_4, 8'h80);
    wait_frames(base + 1);
    if (frames.size() > base) begin
      f = frames[base];
      n_checks += 8;
      if (f.value !== 16'h8480) begin n_fail++; $display("FAIL single_copi: got %h required 8480", f.value); end
      if (f.nbits != 16) begin n_fail++; $display("FAIL single_rises: got %0d required 16", f.nbits); end
      if (f.rise_cyc - f.fall_cyc != 33 * CLK_DIV) begin n_fail++; $display("FAIL single_ncs_low: got %0d required %0d", f.rise_cyc - f.fall_cyc, 33 * CLK_DIV); end
      if (f.first_rise - f.fall_cyc != CLK_DIV) begin n_fail++; $display("FAIL single_first_rise: got %0d required %0d", f.first_rise - f.fall_cyc, CLK_DIV); end
      if (f.last_rise - f.first_rise != 30 * CLK_DIV) begin n_fail++; $display("FAIL single_last_rise: got %0d required %0d", f.last_rise - f.first_rise, 30 * CLK_DIV); end
      if (f.done_at_rise !== 1'b1) begin n_fail++; $display("FAIL single_done_align: got %b required 1", f.done_at_rise); end
      if (f.rx !== (CIPO_EN ? 16'hBEEF : 16'h0)) begin n_fail++; $display("FAIL single_rx_data: got %h required %h", f.rx, CIPO_EN ? 16'hBEEF : 16'h0); end
      if (f.rxv !== CIPO_EN) begin n_fail++; $display("FAIL single_rx_valid: got %b required %b", f.rxv, CIPO_EN); end
    end
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (done_total - d0 != 1) begin n_fail++; $display("FAIL single_done_count: got %0d required 1", done_total - d0); end
    if (regs[4] !== 8'h80) begin n_fail++; $display("FAIL single_reg4: got %h required 80", regs[4]); end
  endtask

  task automatic test_loopback();
    logic [6:0] la [6];
    logic [7:0] ld [6];
    logic       lw [6];
    int base;
    la = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h02};
    ld = '{8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h80, 8'h11};
    lw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      base = frames.size();
      send(lw[i], la[i], ld[i]);
      model_write(lw[i], la[i], ld[i]);
      wait_frames(base + 1);
      n_checks++;
      if (frames.size() > base && frames[base].value !== {lw[i], la[i], ld[i]}) begin
        n_fail++; $display("FAIL loop_frame%0d: got %h required %h", i, frames[base].value, {lw[i], la[i], ld[i]});
      end
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (regs[i] !== exp_regs[i]) begin n_fail++; $display("FAIL loop_reg%0d: got %h required %h", i, regs[i], exp_regs[i]); end
    end
  endtask

  task automatic test_random();
    logic w; logic [6:0] a; logic [7:0] d;
    int base;
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom_range(0, 1)); a = 7'($urandom_range(0, 4)); d = 8'($urandom);
      cipo_word = 16'($urandom);
      base = frames.size();
      send(w, a, d);
      model_write(w, a, d);
      wait_frames(base + 1);
      if (frames.size() > base) begin
        n_checks += 2;
        if (frames[base].value !== {w, a, d}) begin n_fail++; $display("FAIL rand_frame%0d: got %h required %h", i, frames[base].value, {w, a, d}); end
        if (frames[base].rx !== (CIPO_EN ? cipo_word : 16'h0)) begin n_fail++; $display("FAIL rand_rx%0d: got %h required %h", i, frames[base].rx, CIPO_EN ? cipo_word : 16'h0); end
      end
    end
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (regs[i] !== exp_regs[i]) begin n_fail++; $display("FAIL rand_reg%0d: got %h required %h", i, regs[i], exp_regs[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = frames.size();
    @(negedge clk);
    cmd_if.cmd_write = 1'b1; cmd_if.cmd_addr = 7'h01; cmd_if.cmd_data = 8'h5A;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 1000 && !cmd_if.cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_if.cmd_write = 1'b1; cmd_if.cmd_addr = 7'h03; cmd_if.cmd_data = 8'hC3;
    for (int i = 0; i < 1000 && !cmd_if.cmd_ready; i++) @(negedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    model_write(1'b1, 7'h01, 8'h5A);
    model_write(1'b1, 7'h03, 8'hC3);
    wait_frames(base + 2);
    if (frames.size() > base + 1) begin
      n_checks += 3;
      if (frames[base].value !== 16'h815A) begin n_fail++; $display("FAIL b2b_frame0: got %h required 815A", frames[base].value); end
      if (frames[base+1].value !== 16'h83C3) begin n_fail++; $display("FAIL b2b_frame1: got %h required 83C3", frames[base+1].value); end
      if (frames[base+1].fall_cyc - frames[base].rise_cyc != CS_GAP) begin
        n_fail++; $display("FAIL b2b_gap: got %0d required %0d", frames[base+1].fall_cyc - frames[base].rise_cyc, CS_GAP);
      end
    end
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (regs[1] !== exp_regs[1]) begin n_fail++; $display("FAIL b2b_reg1: got %h required %h", regs[1], exp_regs[1]); end
    if (regs[3] !== exp_regs[3]) begin n_fail++; $display("FAIL b2b_reg3: got %h required %h", regs[3], exp_regs[3]); end
  endtask

  task automatic test_midframe_change();
    int base;
    base = frames.size();
    send(1'b1, 7'h00, 8'h3E);
    model_write(1'b1, 7'h00, 8'h3E);
    for (int i = 0; i < 500 && cur_bits < 5; i++) @(negedge clk);
    cmd_if.cmd_write = 1'b0; cmd_if.cmd_addr = 7'h7F; cmd_if.cmd_data = 8'hFF;
    cmd_if.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_frames(base + 1);
    repeat (250) @(negedge clk);
    n_checks += 3;
    if (frames.size() > base && frames[base].value !== 16'h803E) begin n_fail++; $display("FAIL mid_frame: got %h required 803E", frames[base].value); end
    if (frames.size() != base + 1) begin n_fail++; $display("FAIL mid_extra: got %0d frames required %0d", frames.size() - base, 1); end
    if (regs[0] !== 8'h3E) begin n_fail++; $display("FAIL mid_reg0: got %h required 3E", regs[0]); end
  endtask

  task automatic test_reset_midframe();
    int base;
    base = frames.size();
    send(1'b1, 7'h01, 8'h77);
    for (int i = 0; i < 500 && cur_bits < 7; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (ncs !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ncs: got %b required 1", ncs); end
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk: got %b required 0", sclk); end
    if (copi !== 1'b0) begin n_fail++; $display("FAIL rstmid_copi: got %b required 0", copi); end
    if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", cmd_if.cmd_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    send(1'b1, REG_ADDR_2, 8'h3C);
    model_write(1'b1, REG_ADDR_2, 8'h3C);
    wait_frames(base + 1);
    repeat (20) @(negedge clk);
    n_checks += 4;
    if (frames.size() > base && frames[base].value !== 16'h823C) begin n_fail++; $display("FAIL rstmid_frame: got %h required 823C", frames[base].value); end
    if (frames.size() != base + 1) begin n_fail++; $display("FAIL rstmid_count: got %0d frames required 1", frames.size() - base); end
    if (regs[2] !== 8'h3C) begin n_fail++; $display("FAIL rstmid_reg2: got %h required 3C", regs[2]); end
    if (regs[1] !== exp_regs[1]) begin n_fail++; $display("FAIL rstmid_reg1: got %h required %h", regs[1], exp_regs[1]); end
  endtask

  task automatic test_flags();
    n_checks += 3;
    if (flag_err != 0) begin n_fail++; $display("FAIL busy_ready: got %0d bad cycles required 0", flag_err); end
    if (rxv_err != 0)  begin n_fail++; $display("FAIL rx_valid_track: got %0d bad cycles required 0", rxv_err); end
    if (done_total != frames.size()) begin n_fail++; $display("FAIL done_total: got %0d required %0d", done_total, frames.size()); end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_addr  = 7'h00;
    cmd_if.cmd_data  = 8'h00;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    test_reset();
    test_single_write();
    test_loopback();
    test_random();
    test_back_to_back();
    test_midframe_change();
    test_reset_midframe();
    test_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
